// File: rtl/dcache_ram_pkg.sv
// dcache_ram_pkg: clear-sequencer state type and width helpers shared by the way RAM
package dcache_ram_pkg;
  typedef enum logic {INIT, READY} state_t;
  function automatic int be_width(input int data_width, input int byte_size);
    return data_width / byte_size;
  endfunction
  function automatic int way_idx_width(input int ways);
    return ways > 1 ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/dcache_way_bank.sv
// dcache_way_bank: one cache way, simple dual-port byte-enabled array with registered read
module dcache_way_bank
  import dcache_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           we,
  input  logic [ADDR_WIDTH-1:0]                          waddr,
  input  logic [DATA_WIDTH-1:0]                          wdata,
  input  logic [be_width(DATA_WIDTH, BYTE_SIZE)-1:0]     wbe,
  input  logic                                           re,
  input  logic [ADDR_WIDTH-1:0]                          raddr,
  output logic [DATA_WIDTH-1:0]                          q
);
  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // byte-lane writes; the array itself is cleared by the sequencer, not by reset
  always_ff @(posedge clk)
    for (int i = 0; i < BE_WIDTH; i++)
      if (we && wbe[i]) mem[waddr][i*BYTE_SIZE +: BYTE_SIZE] <= wdata[i*BYTE_SIZE +: BYTE_SIZE];
  // registered read returns pre-write contents; the top merges same-cycle writes
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (re) q <= mem[raddr];
endmodule

// File: rtl/dcache_way_ram.sv
// dcache_way_ram: multi-way data RAM with clear sequencer, write-first forwarding and optional output register
module dcache_way_ram
  import dcache_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int WAYS       = 4,
  parameter bit OUTPUT_REG = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       init_req,
  output logic                                       init_busy,
  input  logic                                       wr_en,
  input  logic [way_idx_width(WAYS)-1:0]             wr_way,
  input  logic [ADDR_WIDTH-1:0]                      wr_addr,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  input  logic [be_width(DATA_WIDTH, BYTE_SIZE)-1:0] wr_byte_en,
  input  logic                                       rd_en,
  input  logic [ADDR_WIDTH-1:0]                      rd_addr,
  output logic [WAYS*DATA_WIDTH-1:0]                 rd_data,
  output logic                                       rd_valid
);
  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
  localparam int WI = way_idx_width(WAYS);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic init, wr_acc, rd_acc, rd_v1, fwd_hit;
  logic [WI-1:0] fwd_way;
  logic [BE_WIDTH-1:0] fwd_be, bank_be;
  logic [DATA_WIDTH-1:0] fwd_data, bank_data;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic [WAYS*DATA_WIDTH-1:0] q_all, merged;
  assign init = state == INIT;
  assign init_busy = init;
  assign wr_acc = !init && wr_en && !init_req;
  assign rd_acc = !init && rd_en;
  assign bank_addr = init ? cnt : wr_addr;
  assign bank_data = init ? '0 : wr_data;
  assign bank_be = init ? '1 : wr_byte_en;
  // clear sequencer state and address counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // init_req always restarts the clear at 0; counter wrap finishes it
  always_comb begin
    state_nx = init_req ? INIT : (init && &cnt) ? READY : state;
    cnt_nx = (!init_req && init) ? cnt + 1'b1 : '0;
  end
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    localparam logic [WI-1:0] WID = WI'(w);
    dcache_way_bank #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .BYTE_SIZE (BYTE_SIZE)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (init || (wr_acc && wr_way == WID)),
      .waddr(bank_addr),
      .wdata(bank_data),
      .wbe  (bank_be),
      .re   (rd_acc),
      .raddr(rd_addr),
      .q    (q_all[w*DATA_WIDTH +: DATA_WIDTH])
    );
  end
  // remember a same-address write alongside each accepted read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_v1 <= 1'b0;
      fwd_hit <= 1'b0;
      fwd_way <= '0;
      fwd_be <= '0;
      fwd_data <= '0;
    end else begin
      rd_v1 <= rd_acc;
      if (rd_acc) begin
        fwd_hit <= wr_acc && wr_addr == rd_addr;
        fwd_way <= wr_way;
        fwd_be <= wr_byte_en;
        fwd_data <= wr_data;
      end
    end
  // overlay forwarded lanes on the array read to give write-first data
  always_comb begin
    merged = '0;
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < BE_WIDTH; l++)
        merged[w*DATA_WIDTH + l*BYTE_SIZE +: BYTE_SIZE] = (fwd_hit && fwd_way == WI'(w) && fwd_be[l]) ?
          fwd_data[l*BYTE_SIZE +: BYTE_SIZE] : q_all[w*DATA_WIDTH + l*BYTE_SIZE +: BYTE_SIZE];
  end
  if (OUTPUT_REG) begin : g_oreg
    logic v2;
    logic [WAYS*DATA_WIDTH-1:0] d2;
    // extra output stage, loaded only when a read completes
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= rd_v1;
        if (rd_v1) d2 <= merged;
      end
    assign rd_valid = v2;
    assign rd_data = d2;
  end else begin : g_direct
    assign rd_valid = rd_v1;
    assign rd_data = merged;
  end
endmodule

// File: tb/tb_dcache_way_ram.sv
// tb_dcache_way_ram: directed checks of clear sequencing, byte writes, forwarding and read latency
module tb_dcache_way_ram;
  logic clk = 0, rst = 1, init_req = 0, wr_en = 0, rd_en = 0;
  logic [1:0] wr_way = 0;
  logic [8:0] wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic [3:0] wr_byte_en = 0;
  logic busy0, busy1, v0, v1;
  logic [127:0] d0, d1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  dcache_way_ram #(.OUTPUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .init_req(init_req), .init_busy(busy0), .wr_en(wr_en), .wr_way(wr_way),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d0), .rd_valid(v0));
  dcache_way_ram #(.OUTPUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .init_req(init_req), .init_busy(busy1), .wr_en(wr_en), .wr_way(wr_way),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d1), .rd_valid(v1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] way, input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_way = way; wr_addr = a; wr_data = d; wr_byte_en = be;
    tick();
    wr_en = 0;
  endtask

  task automatic do_read(input logic [8:0] a);
    rd_en = 1; rd_addr = a;
    tick();
    rd_en = 0;
  endtask

  task automatic test_reset();
    int n;
    tick(); tick();
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL reset_busy got %b want 1", busy0); end
    tests++; if (v0 !== 1'b0 || v1 !== 1'b0) begin fails++; $display("FAIL reset_valid got %b/%b want 0/0", v0, v1); end
    tests++; if (d0 !== '0 || d1 !== '0) begin fails++; $display("FAIL reset_data got %h/%h want 0", d0, d1); end
    rst = 0;
    n = 0;
    do begin tick(); n++; end while (busy0 && n < 2000);
    tests++; if (n !== 512) begin fails++; $display("FAIL init_len got %0d want 512", n); end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL init_len_oreg busy got %b want 0", busy1); end
  endtask

  task automatic test_clear();
    rd_en = 1; rd_addr = 9'h1FF;
    tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL clear_pre_valid got %b want 0", v0); end
    tick();
    rd_en = 0;
    tests++; if (v0 !== 1'b1) begin fails++; $display("FAIL clear_valid got %b want 1", v0); end
    tests++; if (d0 !== '0) begin fails++; $display("FAIL clear_data got %h want 0", d0); end
    tick();
  endtask

  task automatic test_write_be();
    do_write(2'd2, 9'h005, 32'hDEADBEEF, 4'b0101);
    do_read(9'h005);
    tests++; if (v0 !== 1'b1) begin fails++; $display("FAIL be_valid got %b want 1", v0); end
    tests++; if (d0 !== 128'h00000000_00AD00EF_00000000_00000000) begin fails++; $display("FAIL be_data got %h want %h", d0, 128'h00000000_00AD00EF_00000000_00000000); end
    tick();
    tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL be_valid_drop got %b want 0", v0); end
    tests++; if (d0 !== 128'h00000000_00AD00EF_00000000_00000000) begin fails++; $display("FAIL be_hold got %h want %h", d0, 128'h00000000_00AD00EF_00000000_00000000); end
  endtask

  task automatic test_forward();
    wr_en = 1; wr_way = 2'd1; wr_addr = 9'h010; wr_data = 32'h12345678; wr_byte_en = 4'hF;
    rd_en = 1; rd_addr = 9'h010;
    tick();
    wr_en = 0; rd_en = 0;
    tests++; if (d0 !== 128'h00000000_00000000_12345678_00000000) begin fails++; $display("FAIL fwd_full got %h want %h", d0, 128'h00000000_00000000_12345678_00000000); end
    wr_en = 1; wr_way = 2'd2; wr_addr = 9'h005; wr_data = 32'h11223344; wr_byte_en = 4'b1010;
    rd_en = 1; rd_addr = 9'h005;
    tick();
    wr_en = 0; rd_en = 0;
    tests++; if (d0 !== 128'h00000000_11AD33EF_00000000_00000000) begin fails++; $display("FAIL fwd_partial got %h want %h", d0, 128'h00000000_11AD33EF_00000000_00000000); end
    do_read(9'h005);
    tests++; if (d0 !== 128'h00000000_11AD33EF_00000000_00000000) begin fails++; $display("FAIL fwd_stored got %h want %h", d0, 128'h00000000_11AD33EF_00000000_00000000); end
  endtask

  task automatic test_diff_addr();
    wr_en = 1; wr_way = 2'd0; wr_addr = 9'h020; wr_data = 32'hAAAAAAAA; wr_byte_en = 4'hF;
    rd_en = 1; rd_addr = 9'h010;
    tick();
    wr_en = 0; rd_en = 0;
    tests++; if (d0 !== 128'h00000000_00000000_12345678_00000000) begin fails++; $display("FAIL diff_addr got %h want %h", d0, 128'h00000000_00000000_12345678_00000000); end
    do_read(9'h020);
    tests++; if (d0 !== 128'h00000000_00000000_00000000_AAAAAAAA) begin fails++; $display("FAIL diff_addr_stored got %h want %h", d0, 128'h00000000_00000000_00000000_AAAAAAAA); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    for (int k = 1; k <= 3; k++) do_write(2'd3, 9'(k), 32'h111 * k, 4'hF);
    for (int i = 0; i < 5; i++) begin
      rd_en = i < 3; rd_addr = 9'(i + 1);
      tick();
      tests++; if (v0 !== (i < 3)) begin fails++; $display("FAIL b2b_valid0 cyc %0d got %b want %b", i, v0, i < 3); end
      exp = {32'h111 * (i + 1), 96'b0};
      if (i < 3) begin
        tests++; if (d0 !== exp) begin fails++; $display("FAIL b2b_data0 cyc %0d got %h want %h", i, d0, exp); end
      end
      tests++; if (v1 !== (i >= 1 && i <= 3)) begin fails++; $display("FAIL b2b_valid1 cyc %0d got %b want %b", i, v1, i >= 1 && i <= 3); end
      exp = {32'h111 * i, 96'b0};
      if (i >= 1 && i <= 3) begin
        tests++; if (d1 !== exp) begin fails++; $display("FAIL b2b_data1 cyc %0d got %h want %h", i, d1, exp); end
      end
    end
    rd_en = 0;
  endtask

  task automatic test_init_req();
    int n;
    logic seen;
    repeat (100) tick();
    init_req = 1; wr_en = 1; wr_way = 2'd0; wr_addr = 9'h030; wr_data = 32'hFFFFFFFF; wr_byte_en = 4'hF;
    tick();
    init_req = 0; wr_way = 2'd1; wr_addr = 9'h040; wr_data = 32'h55555555;
    rd_en = 1; rd_addr = 9'h010;
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL initreq_busy got %b want 1", busy0); end
    n = 0; seen = 0;
    do begin tick(); n++; seen |= v0 | v1; end while (busy0 && n < 2000);
    wr_en = 0; rd_en = 0;
    tests++; if (n !== 512) begin fails++; $display("FAIL initreq_len got %0d want 512", n); end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL initreq_rd_ignored got %b want 0", seen); end
    do_read(9'h010);
    tests++; if (v0 !== 1'b1 || d0 !== '0) begin fails++; $display("FAIL initreq_clr10 got %b/%h want 1/0", v0, d0); end
    do_read(9'h030);
    tests++; if (d0 !== '0) begin fails++; $display("FAIL initreq_drop30 got %h want 0", d0); end
    do_read(9'h040);
    tests++; if (d0 !== '0) begin fails++; $display("FAIL initreq_wr_ignored got %h want 0", d0); end
  endtask

  task automatic test_reset_mid_init();
    int n;
    do_write(2'd1, 9'h010, 32'hCAFEF00D, 4'hF);
    do_read(9'h010);
    tests++; if (d0 !== 128'h00000000_00000000_CAFEF00D_00000000) begin fails++; $display("FAIL rmid_pre got %h want %h", d0, 128'h00000000_00000000_CAFEF00D_00000000); end
    init_req = 1;
    tick();
    init_req = 0;
    repeat (256) tick();
    rst = 1;
    #1;
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL rmid_busy got %b want 1", busy0); end
    tests++; if (v0 !== 1'b0 || d0 !== '0 || d1 !== '0) begin fails++; $display("FAIL rmid_out got %b/%h/%h want 0", v0, d0, d1); end
    tick(); tick();
    rst = 0;
    n = 0;
    do begin tick(); n++; end while (busy0 && n < 2000);
    tests++; if (n !== 512) begin fails++; $display("FAIL rmid_len got %0d want 512", n); end
    do_read(9'h010);
    tests++; if (v0 !== 1'b1 || d0 !== '0) begin fails++; $display("FAIL rmid_clr got %b/%h want 1/0", v0, d0); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_be();
    test_forward();
    test_diff_addr();
    test_back_to_back();
    test_init_req();
    test_reset_mid_init();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_way_ram.md
DCACHE_WAY_RAM -- requirements
Module: dcache_way_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning entry address width (depth = 2^ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data bits per way; a multiple of BYTE_SIZE.
REQ-003 SHALL have parameter BYTE_SIZE, default 8, meaning bits per byte-enable lane (8 or 9).
REQ-004 SHALL have parameter WAYS, default 4, meaning number of independent ways read in parallel (1..8).
REQ-005 SHALL have parameter OUTPUT_REG, default 0, meaning 1 adds an output register stage.
REQ-006 SHALL have port clk  input  1  the single clock; all logic rises on it.
REQ-007 SHALL have port rst  input  1  the reset, asynchronous, active-high.
REQ-008 SHALL have port init_req  input  1  one-cycle pulse that requests a full clear.
REQ-009 SHALL have port init_busy  output  1  high while the clear sequence runs.
REQ-010 SHALL have port wr_en  input  1  write strobe.
REQ-011 SHALL have port wr_way  input  clog2(WAYS) (min 1)  target way index.
REQ-012 SHALL have port wr_addr  input  ADDR_WIDTH  write address.
REQ-013 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-014 SHALL have port wr_byte_en  input  DATA_WIDTH/BYTE_SIZE  per-lane write enable.
REQ-015 SHALL have port rd_en  input  1  read strobe.
REQ-016 SHALL have port rd_addr  input  ADDR_WIDTH  read address.
REQ-017 SHALL have port rd_data  output  WAYS*DATA_WIDTH  all ways, way 0 in the LSBs.
REQ-018 SHALL have port rd_valid  output  1  marks rd_data as valid for one cycle.

Function
REQ-019 SHALL implement states INIT and READY; reset exit enters INIT.
REQ-020 INIT SHALL write zero to every way at counter address 0..2^ADDR_WIDTH-1, one address per cycle, taking exactly 2^ADDR_WIDTH cycles.
REQ-021 On the cycle the counter wraps from its maximum, the block SHALL move to READY and drop init_busy.
REQ-022 init_req in READY SHALL re-enter INIT with the counter at 0 on the next cycle; init_req in INIT SHALL restart the counter at 0.
REQ-023 While in INIT, wr_en and rd_en SHALL be ignored: no array write, and rd_valid stays 0.
REQ-024 A write in READY SHALL update only the lanes of way wr_way whose wr_byte_en bit is 1.
REQ-025 rd_valid SHALL assert 1 cycle after an accepted rd_en when OUTPUT_REG=0, and 2 cycles after when OUTPUT_REG=1.
REQ-026 rd_data SHALL hold its last value when no read completes.
REQ-027 A read and a write to the same address in the same cycle SHALL return write-first data: enabled lanes of the written way show new data, all other lanes show old data.
REQ-028 A write to a different address in the same cycle SHALL NOT affect the read result.
REQ-029 Back-to-back reads SHALL be accepted every cycle, with full throughput.

Reset
REQ-030 rst SHALL force state INIT, the counter to 0, init_busy=1, rd_valid=0, rd_data=0, and clear the output-register pipeline.
REQ-031 rst asserted mid-INIT or mid-read SHALL discard in-flight reads and restart the clear from address 0.

Structure
REQ-032 Package dcache_ram_pkg SHALL hold the state enum (INIT, READY) and the functions deriving BE_WIDTH and WAY_IDX_WIDTH.
REQ-033 Sub-module dcache_way_bank SHALL hold one way: a simple dual-port, byte-enabled array with a registered read; it SHALL be instantiated WAYS times via generate.
REQ-034 Forwarding, the clear sequencer and the output register SHALL reside in dcache_way_ram.

Verification
REQ-035 Reset release -> init_busy=1 for exactly 512 cycles (defaults), then 0; a read of address 0x1FF afterwards returns all-zero on every way.
REQ-036 Write way 2, address 0x005, data 0xDEADBEEF, byte enable 4'b0101 over zeros, then read 0x005 -> way 2 = 0x00AD00EF, other ways 0, rd_valid 1 cycle later (OUTPUT_REG=0).
REQ-037 Same-cycle write way 1, address 0x010, data 0x12345678, byte enable 4'b1111 with read of 0x010 -> way 1 returns 0x12345678 on that read.
REQ-038 init_req at cycle 100 of READY with wr_en high -> the write is dropped, init_busy rises next cycle, and all data reads 0 after 512 cycles.
REQ-039 OUTPUT_REG=1, reads issued on 3 consecutive cycles to 0x001/0x002/0x003 -> rd_valid high on 3 consecutive cycles starting 2 cycles after the first read, data in order.
REQ-040 rst pulse at INIT counter value 0x100 -> init_busy stays 1, and the full 512-cycle clear restarts after reset release.
